// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared types and constants for the fighter animation sequencer
package fighter_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'd0,
    MOVE_PUNCH = 2'd1,
    MOVE_KICK  = 2'd2,
    MOVE_BLOCK = 2'd3
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANIM     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } anim_state_t;

  // One 64x64 sprite frame occupies this many ROM words.
  localparam int SPRITE_WORDS = 4096;
  localparam int ROM_ADDR_W   = 14;

endpackage

// File: rtl/frame_tick_counter.sv
// rtl/frame_tick_counter.sv - modulo-N counter of video frame pulses
// Wraps to zero after the terminal count so a stepping sequence restarts without an explicit clear.
module frame_tick_counter #(
  parameter int MODULUS = 4,
  localparam int CW = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic terminal
);

  logic [CW-1:0] count;

  assign terminal = (count == CW'(MODULUS - 1));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fighter_anim_sequencer.sv
// rtl/fighter_anim_sequencer.sv - per-fighter move animation controller
// Outputs only change on the cycle after a frame_start, keeping the sprite datapath tear-free.
module fighter_anim_sequencer
  import fighter_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int PUNCH_FRAMES    = 3,
  parameter int KICK_FRAMES     = 4,
  parameter int COOLDOWN_TICKS  = 8,
  parameter int SPRITE_PIXELS   = SPRITE_WORDS
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  move_req,
  input  logic [1:0]            move_code,
  output logic                  busy,
  output logic [1:0]            sprite_sel,
  output logic [1:0]            frame_idx,
  output logic [ROM_ADDR_W-1:0] rom_base,
  output logic                  anim_done
);

  anim_state_t           state, state_n;
  move_t                 pending, pending_n;
  move_t                 live_code, start_code;
  logic                  live_valid;
  logic [1:0]            sel_n, idx_n, last_idx;
  logic                  done_n, busy_n;
  logic [ROM_ADDR_W-1:0] rom_base_n;
  logic                  step_clear, step_tick, step_last;
  logic                  cd_clear, cd_tick, cd_last;

  assign live_code  = move_t'(move_code);
  assign live_valid = move_req && (move_code != 2'd0);

  frame_tick_counter #(.MODULUS(FRAMES_PER_STEP)) u_step_ctr (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .clear    (step_clear),
    .tick     (step_tick),
    .terminal (step_last)
  );

  frame_tick_counter #(.MODULUS(COOLDOWN_TICKS)) u_cooldown_ctr (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .clear    (cd_clear),
    .tick     (cd_tick),
    .terminal (cd_last)
  );

  always_comb begin
    state_n    = state;
    pending_n  = pending;
    sel_n      = sprite_sel;
    idx_n      = frame_idx;
    done_n     = 1'b0;
    step_clear = 1'b0;
    step_tick  = 1'b0;
    cd_clear   = 1'b0;
    cd_tick    = 1'b0;
    start_code = MOVE_NONE;
    last_idx   = (sprite_sel == MOVE_PUNCH) ? 2'(PUNCH_FRAMES - 1) : 2'(KICK_FRAMES - 1);

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          // A request in the frame_start cycle itself beats the latched one.
          start_code = live_valid ? live_code : pending;
          if (start_code != MOVE_NONE) begin
            pending_n  = MOVE_NONE;
            sel_n      = start_code;
            idx_n      = 2'd0;
            step_clear = 1'b1;
            state_n    = (start_code == MOVE_BLOCK) ? ST_HOLD : ST_ANIM;
          end
        end else if (live_valid) begin
          pending_n = live_code;
        end
      end
      ST_ANIM: begin
        if (frame_start) begin
          step_tick = 1'b1;
          if (step_last) begin
            if (frame_idx == last_idx) begin
              state_n  = ST_COOLDOWN;
              sel_n    = 2'd0;
              idx_n    = 2'd0;
              done_n   = 1'b1;
              cd_clear = 1'b1;
            end else begin
              idx_n = frame_idx + 2'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (frame_start && !(move_req && live_code == MOVE_BLOCK)) begin
          state_n = ST_IDLE;
          sel_n   = 2'd0;
        end
      end
      ST_COOLDOWN: begin
        if (frame_start) begin
          cd_tick = 1'b1;
          if (cd_last) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n     = (state_n != ST_IDLE);
    rom_base_n = ROM_ADDR_W'(int'(idx_n) * SPRITE_PIXELS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pending    <= MOVE_NONE;
      busy       <= 1'b0;
      sprite_sel <= 2'd0;
      frame_idx  <= 2'd0;
      rom_base   <= '0;
      anim_done  <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      busy       <= busy_n;
      sprite_sel <= sel_n;
      frame_idx  <= idx_n;
      rom_base   <= rom_base_n;
      anim_done  <= done_n;
    end
  end

endmodule

// File: doc/fighter_anim_sequencer.md
# fighter_anim_sequencer

Per-fighter move animation controller that sequences the sprite ROM/palette datapath. It accepts move requests (punch, kick, block) from game logic and steps the selected sprite through its frames at a fixed rate of video frames. After each move it enforces a cooldown. It drives the sprite-select and ROM base address consumed by the sprite drawing block, and changes them only at video frame boundaries so no frame tears.

## Interface
Parameters:
- FRAMES_PER_STEP, 4: video frames each animation frame is held (≥2)
- PUNCH_FRAMES, 3: animation frames in punch (1–4)
- KICK_FRAMES, 4: animation frames in kick (1–4)
- COOLDOWN_TICKS, 8: video frames of lockout after punch/kick (≥1)
- SPRITE_PIXELS, 4096: ROM words per animation frame (64×64)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse per video frame (start of vblank)
- move_req  in  1  move request level from game logic
- move_code  in  2  0 none, 1 punch, 2 kick, 3 block
- busy  out  1  high in ANIM, HOLD, COOLDOWN
- sprite_sel  out  2  active move sprite (0 = idle stance)
- frame_idx  out  2  current animation frame
- rom_base  out  14  frame_idx × SPRITE_PIXELS
- anim_done  out  1  one-cycle pulse when a punch/kick finishes

## Operation
- States: IDLE, ANIM, HOLD, COOLDOWN. Reset gives IDLE and all outputs 0. The pending register and tick counter are also cleared.
- IDLE, cycle with move_req=1 and move_code≠0 and no frame_start: latch the code into pending. A later request overwrites pending.
- IDLE on frame_start: the start code is move_req's code if that is valid this cycle, else pending. If there is none, stay.
  - Code 3: go to HOLD with sprite_sel=3, frame_idx=0.
  - Code 1 or 2: go to ANIM with sprite_sel=code, frame_idx=0, tick=0.
  - On any start, clear pending.
- ANIM, on frame_start:
  - If tick=FRAMES_PER_STEP−1: set tick=0.
    - If frame_idx = last frame (PUNCH_FRAMES−1 or KICK_FRAMES−1): go to COOLDOWN, set sprite_sel=0, frame_idx=0, and pulse anim_done.
    - Otherwise frame_idx+1.
  - Else tick+1.
- HOLD, on frame_start: if not (move_req and move_code=3), go to IDLE with sprite_sel=0. There is no cooldown after block.
- COOLDOWN, on frame_start: tick+1. When COOLDOWN_TICKS frame_starts have been counted, go to IDLE with tick=0.
- Requests arriving in ANIM, HOLD or COOLDOWN are dropped; there is no queue. Code 0 is always ignored.
- No frame_start means state and outputs are frozen.
- rom_base is registered alongside frame_idx and is always consistent with it. Width is 14 bits; no overflow for ≤4 frames of 4096.

## Timing
- All state and outputs are registered on posedge vga_clk. Output changes appear the cycle after the qualifying frame_start.
- Kick with defaults, where F0 is the start frame_start:
  - frame_idx steps 0→1→2→3 after F0, F4, F8 and F12.
  - COOLDOWN and the anim_done pulse follow F16.
  - IDLE follows F24.
  - busy is high from the cycle after F0 through the cycle of F24.
- anim_done is exactly one cycle wide and is never asserted for block.
- Asynchronous reset mid-animation forces IDLE and zero outputs immediately. Operation resumes normally on the first frame_start after release.

## Structure
- fighter_pkg holds:
  - the move_t enum (MOVE_NONE/PUNCH/KICK/BLOCK)
  - the anim_state_t enum
  - the SPRITE_PIXELS and ROM address width localparams
- One sub-module, frame_tick_counter: counts frame_start pulses, with a load/clear, a terminal-count output, and a parameterised modulus. It is used for both the step timing and the cooldown.

## Test plan
- Reset, then 5 frame_starts with no request: busy=0, sprite_sel=0, rom_base=0 throughout.
- Kick requested mid-frame before F0, default parameters:
  - frame_idx=0,1,2,3 at F0+1, F4+1, F8+1, F12+1, with rom_base 0, 4096, 8192, 12288.
  - anim_done pulses once at F16+1.
  - busy falls after F24.
- Punch started, then a kick requested during ANIM and during COOLDOWN: both are ignored. After IDLE plus one frame_start with no request, stays IDLE.
- Block held for 6 frame_starts, then released: sprite_sel=3 and frame_idx=0 while held. IDLE at the first frame_start after release; no anim_done.
- move_req asserted in the same cycle as frame_start while a different pending code is latched: the live code wins and pending is cleared.
- reset_n pulsed low at frame_idx=2 of a kick: outputs go to 0 asynchronously. A new punch starts cleanly from frame_idx=0.
